// File: rtl/usb_reg_fe_pkg.sv
// Shared types and reset values for the USB register front-end.
// Used by usb_strobe_sync and usb_reg_fe_burst.
package usb_reg_fe_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_HOLD = 3'd2,
        ST_WR_HOLD = 3'd3,
        ST_TURN    = 3'd4
    } fe_state_t;

    localparam fe_state_t RST_STATE  = ST_IDLE;
    localparam logic      RST_STROBE = 1'b1;
    localparam logic      RST_ISOUT  = 1'b0;

endpackage

// File: rtl/usb_strobe_sync.sv
// Multi-stage synchroniser for the host bus, with edge detection on the
// last stage of rdn/wrn (falling) and cen (rising).
module usb_strobe_sync
    import usb_reg_fe_pkg::*;
#(
    parameter int pSYNC_STAGES = 2,
    parameter int pADDR_WIDTH  = 21,
    parameter int pDATA_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdn,
    input  logic                   wrn,
    input  logic                   cen,
    input  logic [pADDR_WIDTH-1:0] addr,
    input  logic [pDATA_WIDTH-1:0] din,
    output logic                   rdn_s,
    output logic                   wrn_s,
    output logic                   cen_s,
    output logic [pADDR_WIDTH-1:0] addr_s,
    output logic [pDATA_WIDTH-1:0] din_s,
    output logic                   rdn_fall,
    output logic                   wrn_fall,
    output logic                   cen_rise
);

    localparam int W = 3 + pADDR_WIDTH + pDATA_WIDTH;
    // Strobes reset inactive so that leaving reset never fakes an edge.
    localparam logic [W-1:0] RST_VEC = {{3{RST_STROBE}}, {(W-3){1'b0}}};

    logic [pSYNC_STAGES-1:0][W-1:0] pipe_r;
    logic [2:0]                     prev_r;

    // Synchroniser chain plus previous-value register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_r <= {pSYNC_STAGES{RST_VEC}};
            prev_r <= {3{RST_STROBE}};
        end else begin
            pipe_r <= {pipe_r[pSYNC_STAGES-2:0], {rdn, wrn, cen, addr, din}};
            prev_r <= pipe_r[pSYNC_STAGES-1][W-1 -: 3];
        end
    end

    assign {rdn_s, wrn_s, cen_s, addr_s, din_s} = pipe_r[pSYNC_STAGES-1];
    assign rdn_fall = prev_r[2] & ~rdn_s;
    assign wrn_fall = prev_r[1] & ~wrn_s;
    assign cen_rise = ~prev_r[0] & cen_s;

endmodule

// File: rtl/usb_reg_fe_burst.sv
// USB host parallel bus to register-strobe front-end (usb_clk domain).
// Define USB_REG_FE_BURST_EN for burst mode: address latched once per cen-low window, byte counter auto-increments.
module usb_reg_fe_burst
    import usb_reg_fe_pkg::*;
#(
    parameter int pADDR_WIDTH    = 21,
    parameter int pBYTECNT_SIZE  = 7,
    parameter int pDATA_WIDTH    = 8,
    parameter int pREG_RDDLY_LEN = 3,
    parameter int pSYNC_STAGES   = 2
) (
    input  logic                                 usb_clk,
    input  logic                                 rst,
    input  logic [pDATA_WIDTH-1:0]               usb_din,
    output logic [pDATA_WIDTH-1:0]               usb_dout,
    output logic                                 usb_isout,
    input  logic [pADDR_WIDTH-1:0]               usb_addr,
    input  logic                                 usb_rdn,
    input  logic                                 usb_wrn,
    input  logic                                 usb_cen,
    input  logic                                 usb_alen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [pDATA_WIDTH-1:0]               reg_datao,
    input  logic [pDATA_WIDTH-1:0]               reg_datai,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid
);

    localparam int CNT_W = (pREG_RDDLY_LEN > 1) ? $clog2(pREG_RDDLY_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pREG_RDDLY_LEN - 1);

    logic                   rdn_s, wrn_s, cen_s;
    logic                   rdn_fall, wrn_fall, cen_rise;
    logic [pADDR_WIDTH-1:0] addr_s;
    logic [pDATA_WIDTH-1:0] din_s;
    logic                   rd_go_s, wr_go_s;
    logic                   unused_s;
    fe_state_t              state_r;
    logic [CNT_W-1:0]       dly_r;

    assign unused_s = usb_alen;

    usb_strobe_sync #(
        .pSYNC_STAGES (pSYNC_STAGES),
        .pADDR_WIDTH  (pADDR_WIDTH),
        .pDATA_WIDTH  (pDATA_WIDTH)
    ) u_sync (
        .clk      (usb_clk),
        .rst      (rst),
        .rdn      (usb_rdn),
        .wrn      (usb_wrn),
        .cen      (usb_cen),
        .addr     (usb_addr),
        .din      (usb_din),
        .rdn_s    (rdn_s),
        .wrn_s    (wrn_s),
        .cen_s    (cen_s),
        .addr_s   (addr_s),
        .din_s    (din_s),
        .rdn_fall (rdn_fall),
        .wrn_fall (wrn_fall),
        .cen_rise (cen_rise)
    );

    // Access start decode; a write may also start while the bus is turning around
    always_comb begin
        rd_go_s = 1'b0;
        wr_go_s = 1'b0;
        if (!cen_s && state_r == ST_IDLE) begin
            rd_go_s = rdn_fall & wrn_s;
            wr_go_s = wrn_fall & rdn_s;
        end else if (!cen_s && state_r == ST_TURN) begin
            wr_go_s = wrn_fall & rdn_s;
        end else begin
            rd_go_s = 1'b0;
            wr_go_s = 1'b0;
        end
    end

    // Main control FSM with registered strobes, bus direction and read data
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state_r       <= RST_STATE;
            dly_r         <= '0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
            reg_datao     <= '0;
            usb_dout      <= '0;
            usb_isout     <= RST_ISOUT;
        end else begin
            reg_read      <= rd_go_s;
            reg_write     <= wr_go_s;
            reg_addrvalid <= ~cen_s;
            if (wr_go_s) begin
                reg_datao <= din_s;
            end
            if (cen_rise) begin
                state_r   <= ST_IDLE;
                dly_r     <= '0;
                usb_isout <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rd_go_s) begin
                            state_r   <= ST_RD_WAIT;
                            dly_r     <= '0;
                            usb_isout <= 1'b1;
                        end else if (wr_go_s) begin
                            state_r <= ST_WR_HOLD;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (dly_r == CNT_LAST) begin
                            usb_dout <= reg_datai;
                            state_r  <= ST_RD_HOLD;
                        end else begin
                            dly_r <= dly_r + CNT_W'(1);
                        end
                    end
                    ST_RD_HOLD: begin
                        if (rdn_s) begin
                            state_r <= ST_TURN;
                            dly_r   <= '0;
                        end
                    end
                    ST_WR_HOLD: begin
                        if (wrn_s) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_TURN: begin
                        if (wr_go_s) begin
                            usb_isout <= 1'b0;
                            state_r   <= ST_WR_HOLD;
                        end else if (dly_r == CNT_LAST) begin
                            usb_isout <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            dly_r <= dly_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        usb_isout <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef USB_REG_FE_BURST_EN
    logic load_pending_r;

    // Burst addressing: latch on first access of a cen-low window, then count bytes
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            reg_address    <= '0;
            reg_bytecnt    <= '0;
            load_pending_r <= 1'b1;
        end else if (cen_s) begin
            load_pending_r <= 1'b1;
        end else if (rd_go_s || wr_go_s) begin
            if (load_pending_r) begin
                {reg_address, reg_bytecnt} <= addr_s;
                load_pending_r             <= 1'b0;
            end else begin
                reg_bytecnt <= reg_bytecnt + pBYTECNT_SIZE'(1);
            end
        end
    end
`else
    // Per-access addressing straight from the synchronised host address
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            reg_address <= '0;
            reg_bytecnt <= '0;
        end else if (rd_go_s || wr_go_s) begin
            {reg_address, reg_bytecnt} <= addr_s;
        end
    end
`endif

endmodule
